// File: rtl/tx_stream_arbiter_if.sv
// tx_stream_arbiter_if
//   Bundles every signal between the UART TX stream arbiter and its neighbours:
//   the command reader, the dump requester, the capture RAM and the UART TX core.
//   Clock and reset are plain ports of the arbiter and are not carried here.
// Modports
//   slave  : the arbiter's view (requests, RAM data, Tx_Ready in; acks, RAM
//            address, TX write strobe/byte, status out)
//   master : the surrounding system's view (directions reversed)
// Signals
//   Cmd_Req/Cmd_Byte/Cmd_Ack        command reply request, byte and done pulse
//   Dump_Req/Dump_Base/Dump_Ack     dump request, first RAM address and done pulse
//   RAM_Addr/RAM_Data               capture RAM read port (1-cycle latency)
//   Tx_Ready/TX_Write_en/Word_To_Send  UART TX byte handshake
//   Busy/Timeout_Err                arbiter status
interface tx_stream_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              Cmd_Req;
  logic [7:0]        Cmd_Byte;
  logic              Cmd_Ack;
  logic              Dump_Req;
  logic [ADDR_W-1:0] Dump_Base;
  logic              Dump_Ack;
  logic [ADDR_W-1:0] RAM_Addr;
  logic [7:0]        RAM_Data;
  logic              Tx_Ready;
  logic              TX_Write_en;
  logic [7:0]        Word_To_Send;
  logic              Busy;
  logic              Timeout_Err;

  modport slave (
    input  Cmd_Req, Cmd_Byte, Dump_Req, Dump_Base, RAM_Data, Tx_Ready,
    output Cmd_Ack, Dump_Ack, RAM_Addr, TX_Write_en, Word_To_Send, Busy, Timeout_Err
  );

  modport master (
    output Cmd_Req, Cmd_Byte, Dump_Req, Dump_Base, RAM_Data, Tx_Ready,
    input  Cmd_Ack, Dump_Ack, RAM_Addr, TX_Write_en, Word_To_Send, Busy, Timeout_Err
  );
endinterface

// File: rtl/tx_stream_arbiter.sv
// tx_stream_arbiter
//   Shares one UART transmitter between one-byte command replies and capture-RAM
//   sample dumps. Round-robin between the two requesters; a dump is framed as
//   HDR_BYTE, DUMP_LEN RAM bytes, then an 8-bit sum of the data bytes.
//   Every byte waits for Tx_Ready, is written with a single-cycle TX_Write_en,
//   and the cycle after the write ignores Tx_Ready because the UART drops it late.
//   A wait longer than TIMEOUT_CYC cycles aborts the operation with Timeout_Err.
// Ports
//   clk      : system clock, rising edge
//   reset_b  : asynchronous active-low reset
//   bus      : tx_stream_arbiter_if.slave (requests/acks, RAM port, UART handshake,
//              Busy and Timeout_Err status)
module tx_stream_arbiter #(
  parameter int         ADDR_W      = 10,
  parameter int         DUMP_LEN    = 1024,
  parameter logic [7:0] HDR_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic                clk,
  input  logic                reset_b,
  tx_stream_arbiter_if.slave  bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(DUMP_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CMD_WAIT  = 3'd1,
    DUMP_HDR  = 3'd2,
    DUMP_RD   = 3'd3,
    DUMP_CAP  = 3'd4,
    DUMP_SEND = 3'd5,
    DUMP_CSUM = 3'd6,
    FINISH    = 3'd7
  } state_t;

  state_t            state;
  logic              last_dump;    // 1 when the most recent grant went to the dump side
  logic              after_pulse;  // cycle following a TX write: Tx_Ready not trusted
  logic [7:0]        cmd_byte;
  logic [ADDR_W-1:0] dump_base;
  logic [CNT_W-1:0]  count;
  logic [7:0]        data_q;
  logic [7:0]        csum;
  logic [TMO_W-1:0]  tmo_cnt;

  logic              send_state;
  logic [7:0]        tx_byte;
  logic              can_issue;
  logic              tmo_hit;
  logic [CNT_W-1:0]  count_next;

  // Select the byte owed by the current send state and the send/timeout conditions.
  always_comb begin
    send_state = 1'b0;
    tx_byte    = 8'h00;
    case (state)
      CMD_WAIT: begin
        send_state = 1'b1;
        tx_byte    = cmd_byte;
      end
      DUMP_HDR: begin
        send_state = 1'b1;
        tx_byte    = HDR_BYTE;
      end
      DUMP_SEND: begin
        send_state = 1'b1;
        tx_byte    = data_q;
      end
      DUMP_CSUM: begin
        send_state = 1'b1;
        tx_byte    = csum;
      end
      default: begin
        send_state = 1'b0;
        tx_byte    = 8'h00;
      end
    endcase
    // No new write during the pulse itself nor in the cycle after it.
    can_issue  = bus.Tx_Ready & ~bus.TX_Write_en & ~after_pulse;
    tmo_hit    = (tmo_cnt == TMO_LAST);
    count_next = count + CNT_W'(1);
  end

  // Arbitration/framing FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state            <= IDLE;
      last_dump        <= 1'b1;
      after_pulse      <= 1'b0;
      cmd_byte         <= 8'h00;
      dump_base        <= {ADDR_W{1'b0}};
      count            <= {CNT_W{1'b0}};
      data_q           <= 8'h00;
      csum             <= 8'h00;
      tmo_cnt          <= {TMO_W{1'b0}};
      bus.Cmd_Ack      <= 1'b0;
      bus.Dump_Ack     <= 1'b0;
      bus.RAM_Addr     <= {ADDR_W{1'b0}};
      bus.TX_Write_en  <= 1'b0;
      bus.Word_To_Send <= 8'h00;
      bus.Busy         <= 1'b0;
      bus.Timeout_Err  <= 1'b0;
    end else begin
      bus.TX_Write_en <= 1'b0;
      bus.Cmd_Ack     <= 1'b0;
      bus.Dump_Ack    <= 1'b0;
      bus.Timeout_Err <= 1'b0;
      after_pulse     <= bus.TX_Write_en;

      // Shared byte-send wait: issue the write, or count towards the abort.
      // Advancing after the pulse is handled per state below.
      if (send_state && !bus.TX_Write_en) begin
        if (can_issue) begin
          bus.TX_Write_en  <= 1'b1;
          bus.Word_To_Send <= tx_byte;
          tmo_cnt          <= {TMO_W{1'b0}};
        end else if (tmo_hit) begin
          bus.Timeout_Err <= 1'b1;
          if (state == CMD_WAIT) begin
            bus.Cmd_Ack <= 1'b1;
          end else begin
            bus.Dump_Ack <= 1'b1;
          end
          state <= FINISH;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (bus.Cmd_Req && (!bus.Dump_Req || last_dump)) begin
            state     <= CMD_WAIT;
            cmd_byte  <= bus.Cmd_Byte;
            last_dump <= 1'b0;
            tmo_cnt   <= {TMO_W{1'b0}};
            bus.Busy  <= 1'b1;
          end else if (bus.Dump_Req) begin
            state     <= DUMP_HDR;
            dump_base <= bus.Dump_Base;
            last_dump <= 1'b1;
            tmo_cnt   <= {TMO_W{1'b0}};
            bus.Busy  <= 1'b1;
          end
        end
        CMD_WAIT: begin
          if (bus.TX_Write_en) begin
            state       <= FINISH;
            bus.Cmd_Ack <= 1'b1;
          end
        end
        DUMP_HDR: begin
          if (bus.TX_Write_en) begin
            csum         <= 8'h00;
            count        <= {CNT_W{1'b0}};
            bus.RAM_Addr <= dump_base;
            state        <= DUMP_RD;
          end
        end
        DUMP_RD: begin
          // RAM_Addr is already on the bus; data arrives next cycle.
          state <= DUMP_CAP;
        end
        DUMP_CAP: begin
          data_q <= bus.RAM_Data;
          csum   <= csum + bus.RAM_Data;
          state  <= DUMP_SEND;
        end
        DUMP_SEND: begin
          if (bus.TX_Write_en) begin
            count <= count_next;
            if (count_next == LEN_C) begin
              state <= DUMP_CSUM;
            end else begin
              // Address wraps modulo the RAM size.
              bus.RAM_Addr <= dump_base + count_next[ADDR_W-1:0];
              state        <= DUMP_RD;
            end
          end
        end
        DUMP_CSUM: begin
          if (bus.TX_Write_en) begin
            state        <= FINISH;
            bus.Dump_Ack <= 1'b1;
          end
        end
        FINISH: begin
          state    <= IDLE;
          bus.Busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// tb_tx_stream_arbiter
//   Self-checking bench for tx_stream_arbiter (ADDR_W=10, DUMP_LEN=4, TIMEOUT_CYC=16).
//   A table of directed transactions with hand-computed TX byte streams and RAM
//   addresses is applied in a loop, followed by hand-written sequences for
//   arbitration fairness and asynchronous reset in the middle of a dump.
module tb_tx_stream_arbiter;

  localparam int ADDR_W = 10;
  localparam int DUMP_LEN = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset_b = 1'b1;
  always #5 clk = ~clk;

  tx_stream_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  tx_stream_arbiter #(
    .ADDR_W(ADDR_W), .DUMP_LEN(DUMP_LEN), .HDR_BYTE(8'hA5), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset_b(reset_b), .bus(bus)
  );

  // Capture RAM model, one-cycle read latency
  logic [7:0] ram [0:1023];
  always @(posedge clk) bus.RAM_Data <= ram[bus.RAM_Addr];

  // UART model: Tx_Ready stays high one cycle after a write, then low for 'gap' cycles
  int   gap = 0;
  logic stall = 1'b0;
  int   ucnt;
  logic late;
  always @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ucnt <= 0;
      late <= 1'b0;
    end else if (bus.TX_Write_en) begin
      late <= 1'b1;
      ucnt <= gap + 1;
    end else begin
      late <= 1'b0;
      if (ucnt != 0) ucnt <= ucnt - 1;
    end
  end
  assign bus.Tx_Ready = !stall && (late || ucnt == 0);

  int applied = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        is_dump;
    logic [7:0]  cmd_byte;
    logic [9:0]  base;
    int          gap;
    int          stall_after;  // writes before Tx_Ready is held low; -1 = never
    logic        exp_tmo;
    int          exp_n;
    logic [47:0] exp_bytes;    // byte 0 in [47:40]
    logic [39:0] exp_addr;     // RAM address of data byte 0 in [39:30]
  } vec_t;

  vec_t vecs [0:7];

  task automatic do_reset();
    @(negedge clk);
    reset_b = 1'b0;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n_wr, last_wr, ack_cyc, acks, other_acks, tmo_pulses, viol;
    logic prev_ready, tmo_at_ack, got_ack, ack, other;
    logic [7:0] got_b [0:15];
    logic [9:0] got_a [0:15];
    n_wr = 0; last_wr = -10; ack_cyc = -1; acks = 0; other_acks = 0;
    tmo_pulses = 0; viol = 0; tmo_at_ack = 1'b0; got_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      got_b[i] = 8'h00;
      got_a[i] = 10'd0;
    end
    @(negedge clk);
    gap = v.gap;
    stall = (v.stall_after == 0);
    bus.Cmd_Byte = v.cmd_byte;
    bus.Dump_Base = v.base;
    if (v.is_dump) bus.Dump_Req = 1'b1;
    else bus.Cmd_Req = 1'b1;
    prev_ready = !stall && (late || ucnt == 0);
    for (int cyc = 0; cyc < 400 && !got_ack; cyc++) begin
      @(negedge clk);
      if (bus.TX_Write_en) begin
        if (!prev_ready || (cyc - last_wr) < 3) viol++;
        if (n_wr < 16) begin
          got_b[n_wr] = bus.Word_To_Send;
          got_a[n_wr] = bus.RAM_Addr;
        end
        n_wr++;
        last_wr = cyc;
      end
      if (bus.Timeout_Err) tmo_pulses++;
      if (v.stall_after >= 0 && n_wr >= v.stall_after) stall = 1'b1;
      ack = v.is_dump ? bus.Dump_Ack : bus.Cmd_Ack;
      other = v.is_dump ? bus.Cmd_Ack : bus.Dump_Ack;
      if (other) other_acks++;
      if (ack) begin
        got_ack = 1'b1;
        acks++;
        ack_cyc = cyc;
        tmo_at_ack = bus.Timeout_Err;
        bus.Cmd_Req = 1'b0;
        bus.Dump_Req = 1'b0;
      end
      prev_ready = !stall && (late || ucnt == 0);
    end
    // Quiet period: no further writes, acks or timeouts expected
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.TX_Write_en) n_wr++;
      if (bus.Timeout_Err) tmo_pulses++;
      if (bus.Cmd_Ack || bus.Dump_Ack) begin
        if ((v.is_dump && bus.Dump_Ack) || (!v.is_dump && bus.Cmd_Ack)) acks++;
        else other_acks++;
      end
    end
    check($sformatf("v%0d_ack_seen", idx), got_ack, 1);
    check($sformatf("v%0d_nwrites", idx), n_wr, v.exp_n);
    for (int i = 0; i < v.exp_n; i++)
      check($sformatf("v%0d_byte%0d", idx, i), got_b[i], v.exp_bytes[47-8*i -: 8]);
    if (v.is_dump)
      for (int i = 1; i < v.exp_n && i <= DUMP_LEN; i++)
        check($sformatf("v%0d_addr%0d", idx, i-1), got_a[i], v.exp_addr[39-10*(i-1) -: 10]);
    check($sformatf("v%0d_ack_once", idx), acks, 1);
    check($sformatf("v%0d_wrong_ack", idx), other_acks, 0);
    check($sformatf("v%0d_tmo_pulses", idx), tmo_pulses, v.exp_tmo ? 1 : 0);
    check($sformatf("v%0d_tmo_with_ack", idx), tmo_at_ack, v.exp_tmo);
    if (!v.exp_tmo)
      check($sformatf("v%0d_ack_latency", idx), ack_cyc - last_wr, 1);
    check($sformatf("v%0d_ready_rule", idx), viol, 0);
    check($sformatf("v%0d_busy_after", idx), bus.Busy, 0);
    stall = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit expected $finish");
    $fatal(1);
  end

  initial begin
    int   n_wr, n_ack, cmd_left, dump_left;
    logic [2:0] order;
    logic [7:0] first_byte;
    bit   reached;

    vecs[0] = '{1'b0, 8'h3C, 10'd0,    0, -1, 1'b0, 1, {8'h3C, 40'h0}, 40'h0};
    vecs[1] = '{1'b0, 8'h00, 10'd0,    3, -1, 1'b0, 1, {8'h00, 40'h0}, 40'h0};
    vecs[2] = '{1'b0, 8'hFF, 10'd0,    1, -1, 1'b0, 1, {8'hFF, 40'h0}, 40'h0};
    vecs[3] = '{1'b1, 8'h00, 10'd0,    0, -1, 1'b0, 6, 48'hA5_01_02_03_FE_04,
                {10'd0, 10'd1, 10'd2, 10'd3}};
    vecs[4] = '{1'b1, 8'h00, 10'd1022, 0, -1, 1'b0, 6, 48'hA5_10_20_01_02_33,
                {10'd1022, 10'd1023, 10'd0, 10'd1}};
    vecs[5] = '{1'b1, 8'h00, 10'd100,  2, -1, 1'b0, 6, 48'hA5_80_80_FF_01_00,
                {10'd100, 10'd101, 10'd102, 10'd103}};
    vecs[6] = '{1'b0, 8'h55, 10'd0,    0,  0, 1'b1, 0, 48'h0, 40'h0};
    vecs[7] = '{1'b1, 8'h00, 10'd0,    0,  3, 1'b1, 3, 48'hA5_01_02_00_00_00,
                {10'd0, 10'd1, 10'd2, 10'd3}};

    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h03; ram[3] = 8'hFE;
    ram[1022] = 8'h10; ram[1023] = 8'h20;
    ram[100] = 8'h80; ram[101] = 8'h80; ram[102] = 8'hFF; ram[103] = 8'h01;

    bus.Cmd_Req = 1'b0; bus.Cmd_Byte = 8'h00;
    bus.Dump_Req = 1'b0; bus.Dump_Base = 10'd0;

    // Reset state
    #2 reset_b = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.Busy, 0);
    check("rst_txwr", bus.TX_Write_en, 0);
    check("rst_cmd_ack", bus.Cmd_Ack, 0);
    check("rst_dump_ack", bus.Dump_Ack, 0);
    check("rst_tmo", bus.Timeout_Err, 0);
    check("rst_ram_addr", bus.RAM_Addr, 0);
    check("rst_word", bus.Word_To_Send, 0);
    reset_b = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Simultaneous requests after reset: cmd first, then dump, then cmd again
    do_reset();
    gap = 0; stall = 1'b0;
    @(negedge clk);
    bus.Cmd_Byte = 8'h11; bus.Dump_Base = 10'd0;
    bus.Cmd_Req = 1'b1; bus.Dump_Req = 1'b1;
    cmd_left = 2; dump_left = 1; n_ack = 0; n_wr = 0; order = 3'b111; first_byte = 8'h00;
    for (int cyc = 0; cyc < 600 && (cmd_left > 0 || dump_left > 0); cyc++) begin
      @(negedge clk);
      if (bus.TX_Write_en) begin
        if (n_wr == 0) first_byte = bus.Word_To_Send;
        n_wr++;
      end
      if (bus.Cmd_Ack) begin
        if (n_ack < 3) order[n_ack] = 1'b0;
        n_ack++; cmd_left--;
        if (cmd_left <= 0) bus.Cmd_Req = 1'b0;
      end
      if (bus.Dump_Ack) begin
        if (n_ack < 3) order[n_ack] = 1'b1;
        n_ack++; dump_left--;
        if (dump_left <= 0) bus.Dump_Req = 1'b0;
      end
    end
    bus.Cmd_Req = 1'b0; bus.Dump_Req = 1'b0;
    repeat (3) @(negedge clk);
    check("arb_n_acks", n_ack, 3);
    check("arb_order", order, 3'b010);
    check("arb_first_byte", first_byte, 8'h11);
    check("arb_n_writes", n_wr, 8);

    // Asynchronous reset while the dump waits to send a data byte
    gap = 3; stall = 1'b0; n_wr = 0; reached = 1'b0;
    @(negedge clk);
    bus.Dump_Base = 10'd0; bus.Dump_Req = 1'b1;
    for (int cyc = 0; cyc < 200 && !reached; cyc++) begin
      @(negedge clk);
      if (bus.TX_Write_en) n_wr++;
      if (n_wr == 2) reached = 1'b1;
    end
    check("mid_reached_byte1", reached, 1);
    repeat (3) @(negedge clk);
    check("mid_busy_before", bus.Busy, 1);
    #2 reset_b = 1'b0;
    #1;
    check("mid_rst_busy", bus.Busy, 0);
    check("mid_rst_txwr", bus.TX_Write_en, 0);
    check("mid_rst_ram_addr", bus.RAM_Addr, 0);
    check("mid_rst_word", bus.Word_To_Send, 0);
    check("mid_rst_dump_ack", bus.Dump_Ack, 0);
    bus.Dump_Req = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    n_ack = 0; n_wr = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.Dump_Ack || bus.Cmd_Ack) n_ack++;
      if (bus.TX_Write_en) n_wr++;
    end
    check("mid_no_ack", n_ack, 0);
    check("mid_no_writes", n_wr, 0);
    check("mid_idle", bus.Busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
